// File: rtl/huil_status_encoder.sv
// Window-averages amplitude samples and encodes a 0..7 stress status with downward hysteresis.
// Latency 1 cycle after the completing sample; no backpressure. Optional macro STATUS_HOLD_EN delays decreases.
module huil_status_encoder #(
    parameter int SAMPLE_W = 8,
    parameter int WIN_LOG2 = 6,
    parameter int HYST     = 4,
    parameter int HOLD_WIN = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic [2:0]          status,
    output logic                status_update,
    output logic [SAMPLE_W-1:0] level
);
    localparam int ACC_W  = SAMPLE_W + WIN_LOG2;
    localparam int HYST_W = $clog2(HYST + 1);
    localparam int CMP_W  = ((SAMPLE_W > HYST_W) ? SAMPLE_W : HYST_W) + 1;
    localparam logic [CMP_W-1:0] HYST_C = CMP_W'(HYST);

    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [2:0]          status_q, status_d;
    logic [SAMPLE_W-1:0] level_q, level_d;
    logic                upd_q, upd_d;

    logic [ACC_W-1:0]    sum;
    logic [SAMPLE_W-1:0] avg;
    logic [SAMPLE_W-1:0] thresh;
    logic [2:0]          raw;
    logic                win_done;
    logic                dec_cond;

    assign sum      = acc_q + ACC_W'(sample_in);
    assign avg      = sum[ACC_W-1:WIN_LOG2];
    assign raw      = avg[SAMPLE_W-1 -: 3];
    assign thresh   = {status_q, {(SAMPLE_W-3){1'b0}}};
    assign win_done = sample_valid && (cnt_q == '1);
    // Widened compare so avg + HYST cannot wrap below the bucket floor.
    assign dec_cond = (raw < status_q) && ((CMP_W'(avg) + HYST_C) < CMP_W'(thresh));

`ifdef STATUS_HOLD_EN
    localparam logic [3:0] HOLD_C = 4'(HOLD_WIN);
    logic [3:0] hold_q, hold_d;
`endif

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        status_d = status_q;
        upd_d    = 1'b0;
`ifdef STATUS_HOLD_EN
        hold_d   = hold_q;
`endif
        if (sample_valid) begin
            if (win_done) begin
                acc_d   = '0;
                cnt_d   = '0;
                level_d = avg;
                upd_d   = 1'b1;
`ifdef STATUS_HOLD_EN
                // Any window not qualifying as a decrease breaks the consecutive run.
                hold_d = '0;
                if (raw > status_q) begin
                    status_d = raw;
                end else if (dec_cond) begin
                    if (hold_q + 4'd1 >= HOLD_C) begin
                        status_d = raw;
                    end else begin
                        hold_d = hold_q + 4'd1;
                    end
                end
`else
                if ((raw > status_q) || dec_cond) begin
                    status_d = raw;
                end
`endif
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            status_q <= '0;
            level_q  <= '0;
            upd_q    <= 1'b0;
`ifdef STATUS_HOLD_EN
            hold_q   <= '0;
`endif
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            level_q  <= level_d;
            upd_q    <= upd_d;
`ifdef STATUS_HOLD_EN
            hold_q   <= hold_d;
`endif
        end
    end

    assign status        = status_q;
    assign status_update = upd_q;
    assign level         = level_q;

endmodule

// File: tb/tb_huil_status_encoder.sv
// Directed bench for huil_status_encoder with 4-sample windows, 8-bit samples, HYST=4 (bucket width 32).
module tb_huil_status_encoder;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic [2:0] status;
    logic       status_update;
    logic [7:0] level;
    int n_vec = 0;
    int n_err = 0;

    huil_status_encoder #(.SAMPLE_W(8), .WIN_LOG2(2), .HYST(4), .HOLD_WIN(2)) dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .status(status), .status_update(status_update), .level(level)
    );

    always #5 clk = ~clk;

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] v);
        sample_in = v; sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic send_window(input logic [7:0] v);
        for (int i = 0; i < 4; i++) send(v);
    endtask

    task automatic test_reset();
        reset = 1'b1; sample_valid = 1'b0; sample_in = '0;
        idle(); idle();
        reset = 1'b0;
        if (status !== 3'd0) begin n_err++; $display("FAIL rst_status got=%0d exp=0", status); end n_vec++;
        if (level !== 8'd0) begin n_err++; $display("FAIL rst_level got=%0d exp=0", level); end n_vec++;
        if (status_update !== 1'b0) begin n_err++; $display("FAIL rst_update got=%b exp=0", status_update); end n_vec++;
    endtask

    task automatic test_truncation();
        send(8'd1); send(8'd2); send(8'd3);
        if (status_update !== 1'b0) begin n_err++; $display("FAIL trunc_early_pulse got=%b exp=0", status_update); end n_vec++;
        send(8'd3);
        if (level !== 8'd2) begin n_err++; $display("FAIL trunc_level got=%0d exp=2", level); end n_vec++;
        if (status !== 3'd0) begin n_err++; $display("FAIL trunc_status got=%0d exp=0", status); end n_vec++;
        if (status_update !== 1'b1) begin n_err++; $display("FAIL trunc_pulse got=%b exp=1", status_update); end n_vec++;
        idle();
        if (status_update !== 1'b0) begin n_err++; $display("FAIL trunc_pulse_len got=%b exp=0", status_update); end n_vec++;
    endtask

    task automatic test_increase();
        send_window(8'd100);
        if (level !== 8'd100) begin n_err++; $display("FAIL t1_level got=%0d exp=100", level); end n_vec++;
        if (status !== 3'd3) begin n_err++; $display("FAIL t1_status got=%0d exp=3", status); end n_vec++;
        if (status_update !== 1'b1) begin n_err++; $display("FAIL t1_pulse got=%b exp=1", status_update); end n_vec++;
        idle();
        if (status_update !== 1'b0) begin n_err++; $display("FAIL t1_pulse_len got=%b exp=0", status_update); end n_vec++;
        if (status !== 3'd3) begin n_err++; $display("FAIL t1_status_stable got=%0d exp=3", status); end n_vec++;
    endtask

    task automatic test_hyst_hold();
        send_window(8'd95);
        if (level !== 8'd95) begin n_err++; $display("FAIL t2_level got=%0d exp=95", level); end n_vec++;
        if (status !== 3'd3) begin n_err++; $display("FAIL t2_status got=%0d exp=3", status); end n_vec++;
        if (status_update !== 1'b1) begin n_err++; $display("FAIL t2_pulse got=%b exp=1", status_update); end n_vec++;
    endtask

    task automatic test_decrease();
`ifdef STATUS_HOLD_EN
        send_window(8'd90);
        if (status !== 3'd3) begin n_err++; $display("FAIL t3_held got=%0d exp=3", status); end n_vec++;
`endif
        send_window(8'd90);
        if (level !== 8'd90) begin n_err++; $display("FAIL t3_level got=%0d exp=90", level); end n_vec++;
        if (status !== 3'd2) begin n_err++; $display("FAIL t3_status got=%0d exp=2", status); end n_vec++;
    endtask

`ifndef STATUS_HOLD_EN
    task automatic test_hyst_edge();
        send_window(8'd60);
        if (status !== 3'd2) begin n_err++; $display("FAIL edge60_status got=%0d exp=2", status); end n_vec++;
        if (status_update !== 1'b1) begin n_err++; $display("FAIL edge60_pulse got=%b exp=1", status_update); end n_vec++;
        send_window(8'd59);
        if (status !== 3'd1) begin n_err++; $display("FAIL edge59_status got=%0d exp=1", status); end n_vec++;
        if (level !== 8'd59) begin n_err++; $display("FAIL edge59_level got=%0d exp=59", level); end n_vec++;
    endtask
`endif

    task automatic test_gaps();
        for (int i = 0; i < 4; i++) begin
            send(8'd255);
            if (i < 3) begin
                if (status_update !== 1'b0) begin n_err++; $display("FAIL t4_early_pulse[%0d] got=%b exp=0", i, status_update); end n_vec++;
                for (int g = 0; g < 3; g++) begin
                    idle();
                    if (status_update !== 1'b0) begin n_err++; $display("FAIL t4_gap_pulse[%0d.%0d] got=%b exp=0", i, g, status_update); end n_vec++;
                end
            end
        end
        if (status_update !== 1'b1) begin n_err++; $display("FAIL t4_pulse got=%b exp=1", status_update); end n_vec++;
        if (level !== 8'd255) begin n_err++; $display("FAIL t4_level got=%0d exp=255", level); end n_vec++;
        if (status !== 3'd7) begin n_err++; $display("FAIL t4_status got=%0d exp=7", status); end n_vec++;
        idle();
        if (status_update !== 1'b0) begin n_err++; $display("FAIL t4_pulse_len got=%b exp=0", status_update); end n_vec++;
    endtask

    task automatic test_reset_on_complete();
        send(8'd255); send(8'd255); send(8'd255);
        sample_in = 8'd255; sample_valid = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0; reset = 1'b0;
        if (status_update !== 1'b0) begin n_err++; $display("FAIL rc_pulse got=%b exp=0", status_update); end n_vec++;
        if (status !== 3'd0) begin n_err++; $display("FAIL rc_status got=%0d exp=0", status); end n_vec++;
        if (level !== 8'd0) begin n_err++; $display("FAIL rc_level got=%0d exp=0", level); end n_vec++;
        idle();
        if (status_update !== 1'b0) begin n_err++; $display("FAIL rc_late_pulse got=%b exp=0", status_update); end n_vec++;
        send_window(8'd10);
        if (level !== 8'd10) begin n_err++; $display("FAIL rc_next_level got=%0d exp=10", level); end n_vec++;
    endtask

    task automatic test_partial_discard();
        send(8'd200); send(8'd200);
        reset = 1'b1; idle(); reset = 1'b0;
        if (level !== 8'd0) begin n_err++; $display("FAIL t5_rst_level got=%0d exp=0", level); end n_vec++;
        send_window(8'd10);
        if (level !== 8'd10) begin n_err++; $display("FAIL t5_level got=%0d exp=10", level); end n_vec++;
        if (status !== 3'd0) begin n_err++; $display("FAIL t5_status got=%0d exp=0", status); end n_vec++;
        if (status_update !== 1'b1) begin n_err++; $display("FAIL t5_pulse got=%b exp=1", status_update); end n_vec++;
    endtask

    task automatic test_hold();
        send_window(8'd255);
        if (status !== 3'd7) begin n_err++; $display("FAIL t6_up got=%0d exp=7", status); end n_vec++;
`ifdef STATUS_HOLD_EN
        send_window(8'd10);
        if (status !== 3'd7) begin n_err++; $display("FAIL t6_hold1 got=%0d exp=7", status); end n_vec++;
        send_window(8'd10);
        if (status !== 3'd0) begin n_err++; $display("FAIL t6_drop got=%0d exp=0", status); end n_vec++;
        send_window(8'd255);
        if (status !== 3'd7) begin n_err++; $display("FAIL t6_up2 got=%0d exp=7", status); end n_vec++;
        send_window(8'd10);
        if (status !== 3'd7) begin n_err++; $display("FAIL t6_hold2 got=%0d exp=7", status); end n_vec++;
        send_window(8'd250);
        if (status !== 3'd7) begin n_err++; $display("FAIL t6_clear got=%0d exp=7", status); end n_vec++;
        send_window(8'd10);
        if (status !== 3'd7) begin n_err++; $display("FAIL t6_hold3 got=%0d exp=7", status); end n_vec++;
        send_window(8'd10);
        if (status !== 3'd0) begin n_err++; $display("FAIL t6_drop2 got=%0d exp=0", status); end n_vec++;
`else
        send_window(8'd10);
        if (status !== 3'd0) begin n_err++; $display("FAIL t6_nohold_drop got=%0d exp=0", status); end n_vec++;
        if (level !== 8'd10) begin n_err++; $display("FAIL t6_nohold_level got=%0d exp=10", level); end n_vec++;
`endif
    endtask

    initial begin
        test_reset();
        test_truncation();
        test_increase();
        test_hyst_hold();
        test_decrease();
`ifndef STATUS_HOLD_EN
        test_hyst_edge();
`endif
        test_gaps();
        test_reset_on_complete();
        test_partial_discard();
        test_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
